// File: rtl/stopwatch_core.sv
// MM:SS.cc stopwatch with debounced keys and a 6-digit multiplexed 7-segment scan.
// Optional lap-hold display is built when STOPWATCH_LAP_EN is defined.

module stopwatch_debounce #(
    parameter int DEB_N = 3
) (
    input  logic clk_50mhz,
    input  logic rst,
    input  logic tick,
    input  logic key,
    output logic press
);
    logic       level;
    logic [7:0] cnt;

    // level is the accepted key level; cnt counts consecutive samples that disagree with it
    always_ff @(posedge clk_50mhz) begin
        if (!rst) begin
            level <= 1'b1;
            cnt   <= '0;
        end else if (tick) begin
            if (key != level) begin
                if (cnt == 8'(DEB_N - 1)) begin
                    level <= key;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = tick && level && !key && (cnt == 8'(DEB_N - 1));
endmodule

module stopwatch_core #(
    parameter int DEB_N    = 3,
    parameter int SCAN_DIV = 1
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic       clk_100hz,
    input  logic       clk_1khz,
    input  logic       key_start,
    input  logic       key_clear,
    input  logic       key_lap,
    output logic [7:0] seg,
    output logic [5:0] an,
    output logic       running
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t      state, state_next;
    logic        c100_s1, c100_s2, c1k_s1, c1k_s2;
    logic        tick_100, tick_1k;
    logic        start_evt, clear_evt;
    logic        time_clr, time_inc;
    logic [23:0] tm;
    logic [23:0] disp;
    logic [2:0]  idx;
    logic [15:0] scan_cnt;
    logic [3:0]  digit;

    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [23:0] r;
        logic        c;
        logic [3:0]  lim;
        r = t;
        c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (c) begin
                if (t[i*4 +: 4] == lim) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = t[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Divided clocks are plain data here: sample twice, pulse on the rising edge
    always_ff @(posedge clk_50mhz) begin
        if (!rst) begin
            c100_s1 <= 1'b0;
            c100_s2 <= 1'b0;
            c1k_s1  <= 1'b0;
            c1k_s2  <= 1'b0;
        end else begin
            c100_s1 <= clk_100hz;
            c100_s2 <= c100_s1;
            c1k_s1  <= clk_1khz;
            c1k_s2  <= c1k_s1;
        end
    end

    assign tick_100 = c100_s1 & ~c100_s2;
    assign tick_1k  = c1k_s1 & ~c1k_s2;

    stopwatch_debounce #(.DEB_N(DEB_N)) u_deb_start (
        .clk_50mhz(clk_50mhz), .rst(rst), .tick(tick_100), .key(key_start), .press(start_evt)
    );
    stopwatch_debounce #(.DEB_N(DEB_N)) u_deb_clear (
        .clk_50mhz(clk_50mhz), .rst(rst), .tick(tick_100), .key(key_clear), .press(clear_evt)
    );

    always_comb begin
        state_next = state;
        time_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (clear_evt) time_clr = 1'b1;
                else if (start_evt) state_next = RUN;
            end
            RUN: begin
                if (start_evt) state_next = PAUSE;
            end
            PAUSE: begin
                if (clear_evt) begin
                    state_next = IDLE;
                    time_clr   = 1'b1;
                end else if (start_evt) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counting looks at the current state, so the start tick is skipped and the pause tick counts
    assign time_inc = tick_100 && (state == RUN);

    always_ff @(posedge clk_50mhz) begin
        if (!rst) begin
            state   <= IDLE;
            running <= 1'b0;
            tm      <= '0;
        end else begin
            state   <= state_next;
            running <= (state == RUN);
            if (time_clr) tm <= '0;
            else if (time_inc) tm <= bcd_inc(tm);
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic        lap_evt;
    logic        hold;
    logic [23:0] snap;

    stopwatch_debounce #(.DEB_N(DEB_N)) u_deb_lap (
        .clk_50mhz(clk_50mhz), .rst(rst), .tick(tick_100), .key(key_lap), .press(lap_evt)
    );

    always_ff @(posedge clk_50mhz) begin
        if (!rst) begin
            hold <= 1'b0;
            snap <= '0;
        end else if (time_clr) begin
            hold <= 1'b0;
        end else if (lap_evt && state == RUN) begin
            hold <= !hold;
            if (!hold) snap <= tm;
        end
    end

    assign disp = hold ? snap : tm;
`else
    logic key_lap_unused;
    assign key_lap_unused = key_lap;
    assign disp = tm;
`endif

    always_comb begin
        case (idx)
            3'd0:    digit = disp[3:0];
            3'd1:    digit = disp[7:4];
            3'd2:    digit = disp[11:8];
            3'd3:    digit = disp[15:12];
            3'd4:    digit = disp[19:16];
            3'd5:    digit = disp[23:20];
            default: digit = 4'hF;
        endcase
    end

    // seg/an load the digit at idx, then idx moves on; dp marks seconds and minutes ones
    always_ff @(posedge clk_50mhz) begin
        if (!rst) begin
            idx      <= '0;
            scan_cnt <= '0;
            seg      <= 8'hFF;
            an       <= 6'h3F;
        end else if (tick_1k) begin
            if (scan_cnt == 16'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                an       <= ~(6'b1 << idx);
                seg      <= {!(idx == 3'd2 || idx == 3'd4), seg7(digit)};
                idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: keys, counting, priority, rollover, scan and lap hold.
module tb_stopwatch_core;
    logic       clk_50mhz = 1'b0;
    logic       rst = 1'b0;
    logic       clk_100hz = 1'b0;
    logic       clk_1khz = 1'b0;
    logic       key_start = 1'b1;
    logic       key_clear = 1'b1;
    logic       key_lap = 1'b1;
    logic [7:0] seg;
    logic [5:0] an;
    logic       running;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    stopwatch_core #(.DEB_N(3), .SCAN_DIV(1)) dut (
        .clk_50mhz(clk_50mhz), .rst(rst), .clk_100hz(clk_100hz), .clk_1khz(clk_1khz),
        .key_start(key_start), .key_clear(key_clear), .key_lap(key_lap),
        .seg(seg), .an(an), .running(running)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          model_cs = 0;
    int          sidx = 0;
    int          snap_cs = 0;
    logic [6:0]  segtab[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic compare_next(input logic [31:0] got);
        string       t;
        logic [31:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        check_eq(t, got, e);
    endtask

    function automatic logic [23:0] to_bcd(input int cs);
        int c, s, m;
        c = cs % 100;
        s = (cs / 100) % 60;
        m = cs / 6000;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic tick100(input int n, input bit counted);
        repeat (n) begin
            @(negedge clk_50mhz) clk_100hz = 1'b1;
            @(negedge clk_50mhz) clk_100hz = 1'b0;
            @(negedge clk_50mhz);
            if (counted) model_cs = (model_cs + 1) % 360000;
        end
    endtask

    task automatic tick1k();
        @(negedge clk_50mhz) clk_1khz = 1'b1;
        @(negedge clk_50mhz) clk_1khz = 1'b0;
        @(negedge clk_50mhz);
    endtask

    task automatic check_display(input string tag, input logic [23:0] t);
        logic [3:0] d;
        logic [7:0] es;
        logic [5:0] ea;
        for (int i = 0; i < 6; i++) begin
            d  = t[sidx*4 +: 4];
            es = {(sidx == 2 || sidx == 4) ? 1'b0 : 1'b1, segtab[d]};
            ea = ~(6'b1 << sidx);
            expect_val($sformatf("%s_dig%0d", tag, sidx), {18'b0, es, ea});
            tick1k();
            compare_next({18'b0, seg, an});
            sidx = (sidx + 1) % 6;
        end
    endtask

    task automatic check_run(input string tag, input logic e);
        expect_val(tag, {31'b0, e});
        compare_next({31'b0, running});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk_50mhz);
        expect_val("reset_seg", 32'hFF); compare_next({24'b0, seg});
        expect_val("reset_an", 32'h3F);  compare_next({26'b0, an});
        check_run("reset_running", 1'b0);
        rst = 1'b1;
        check_display("init", to_bcd(model_cs));

        // bounce: 2 low, 1 high, 2 low never reaches three agreeing samples
        key_start = 1'b0; tick100(2, 0);
        key_start = 1'b1; tick100(1, 0);
        key_start = 1'b0; tick100(2, 0);
        key_start = 1'b1; tick100(3, 0);
        check_run("bounce_running", 1'b0);
        check_display("bounce", to_bcd(model_cs));

        key_start = 1'b0; tick100(3, 0);
        check_run("start_lag", 1'b0);
        @(negedge clk_50mhz);
        check_run("start_running", 1'b1);
        key_start = 1'b1; tick100(150, 1);
        check_display("run150", to_bcd(model_cs));

        @(negedge clk_50mhz) rst = 1'b0;
        @(negedge clk_50mhz);
        expect_val("midrst_seg", 32'hFF); compare_next({24'b0, seg});
        expect_val("midrst_an", 32'h3F);  compare_next({26'b0, an});
        check_run("midrst_running", 1'b0);
        rst = 1'b1;
        model_cs = 0;
        sidx = 0;
        check_display("post_rst", to_bcd(model_cs));

        // run to 00:12.34 and pause; the pausing tick is counted
        key_start = 1'b0; tick100(3, 0);
        key_start = 1'b1; tick100(1231, 1);
        key_start = 1'b0; tick100(3, 1);
        key_start = 1'b1; tick100(3, 0);
        check_run("pause_running", 1'b0);
        check_display("pause", to_bcd(model_cs));

        key_start = 1'b0; key_clear = 1'b0; tick100(3, 0);
        model_cs = 0;
        key_start = 1'b1; key_clear = 1'b1; tick100(3, 0);
        check_run("clrpri_running", 1'b0);
        check_display("clrpri", to_bcd(model_cs));

        key_start = 1'b0; tick100(3, 0);
        key_start = 1'b1; tick100(47, 1);
        key_start = 1'b0; key_clear = 1'b0; tick100(3, 1);
        key_start = 1'b1; key_clear = 1'b1; tick100(3, 0);
        check_run("runpri_running", 1'b0);
        check_display("runpri", to_bcd(model_cs));

        @(negedge clk_50mhz) force dut.tm = 24'h595999;
        @(negedge clk_50mhz) release dut.tm;
        model_cs = 359999;
        check_display("preload", to_bcd(model_cs));
        key_start = 1'b0; tick100(3, 0);
        key_start = 1'b1; tick100(1, 1);
        check_display("rollover", to_bcd(model_cs));
        check_run("rollover_running", 1'b1);
        tick100(2, 1);

        // lap: snapshot is the time seen in the event cycle, before that tick's increment
        tick100(198 - model_cs, 1);
        key_lap = 1'b0; tick100(2, 1);
        snap_cs = model_cs;
        tick100(1, 1);
        key_lap = 1'b1; tick100(99, 1);
        check_display("lap_hold", LAP ? to_bcd(snap_cs) : to_bcd(model_cs));
        key_lap = 1'b0; tick100(3, 1);
        key_lap = 1'b1; tick100(3, 1);
        check_display("lap_live", to_bcd(model_cs));

        key_lap = 1'b0; tick100(2, 1);
        snap_cs = model_cs;
        tick100(1, 1);
        key_lap = 1'b1; tick100(3, 1);
        key_start = 1'b0; tick100(3, 1);
        key_start = 1'b1; tick100(3, 0);
        check_display("lap_pause", LAP ? to_bcd(snap_cs) : to_bcd(model_cs));
        key_clear = 1'b0; tick100(3, 0);
        model_cs = 0;
        key_clear = 1'b1; tick100(3, 0);
        check_display("lap_clear", to_bcd(model_cs));
        check_run("final_running", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Stopwatch that consumes the divided clocks from the frequency divider stage.
- clk_100hz paces the centisecond time base and key debouncing; clk_1khz paces the 6-digit multiplexed 7-segment display scan.
- Both divided clocks are treated as data and edge-detected in the clk_50mhz domain. No logic runs on the divided clocks as clocks.
- Display format is MM:SS.cc.

Parameters:
- DEB_N, 3: consecutive equal 100 Hz samples needed to accept a key level change (30 ms).
- SCAN_DIV, 1: number of 1 kHz ticks per scan-digit advance.

Ports:
- clk_50mhz  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- clk_100hz  in  1  100 Hz square wave from divider
- clk_1khz  in  1  1 kHz square wave from divider
- key_start  in  1  start/pause push button, active-low
- key_clear  in  1  clear push button, active-low
- key_lap  in  1  lap-hold push button, active-low (used only with LAP_EN)
- seg  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}
- an  out  6  digit enables, active-low; an[0] = centiseconds ones
- running  out  1  high while in RUN

Behaviour:
- Reset is rst, synchronous, active-low, on clk_50mhz. While rst=0:
  - all state and counters are cleared;
  - seg=8'hFF, an=6'h3F, running=0;
  - FSM state is IDLE, time is 00:00.00, scan index is 0;
  - debouncers read "released".
- Edge detect: each divided clock passes through a 2-flop chain (s1<=in, s2<=s1); tick = s1 & ~s2.
  - A tick lasts exactly one clk_50mhz cycle.
  - Consumers update on the edge following the edge that first samples the input high.
- Debounce: each key is sampled only on tick_100.
  - The accepted level changes after DEB_N consecutive samples differ from it.
  - A press event is one cycle long and fires on the accepted high-to-low transition.
  - Holding a key produces exactly one event.
  - A press interrupted before DEB_N samples produces no event.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE --start--> RUN.
  - RUN --start--> PAUSE.
  - PAUSE --start--> RUN.
  - PAUSE --clear--> IDLE, time zeroed.
  - IDLE --clear--> IDLE, time zeroed.
  - Clear is ignored in RUN.
  - If start and clear events fall in the same cycle: in IDLE/PAUSE clear wins and start is dropped; in RUN start wins.
- Time base: 6 BCD digits (cs1 cs0, s1 s0, m1 m0), each 4 bits.
  - Time increments by 0.01 s on tick_100 only when the current state is RUN.
  - A tick in the same cycle as RUN->PAUSE is counted.
  - A tick in the same cycle as IDLE->RUN is not counted.
  - Carries: cs 99->00 carries into seconds; s 59->00 carries into minutes; m 59->00.
  - 59:59.99 rolls over to 00:00.00 and counting continues.
- Scan:
  - The scan index 0..5 advances every SCAN_DIV tick_1k events and wraps 5->0.
  - an drives exactly one low bit, at position = index. The first digit is enabled on the first tick after reset.
  - seg carries the selected digit's standard 7-segment code for BCD 0-9. Illegal BCD values show blank (7'h7F).
  - dp is lit (0) on index 2 (seconds ones) and index 4 (minutes ones).
  - seg and an are registered and change in the same cycle.
- running is registered: (state==RUN).

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - A key_lap press event in RUN toggles display hold. While held, the display shows a snapshot latched in the event cycle, and counting continues underneath.
  - A second lap event releases the hold, and the live time shows from the next cycle.
  - Entering IDLE releases the hold.
  - Lap events in IDLE/PAUSE are ignored.
- Undefined: key_lap is ignored (its debouncer is not built), and the display is always live.

Test Plan:
- Reset mid-count: reach 00:01.23 in RUN, assert rst for 1 cycle -> seg=8'hFF, an=6'h3F, running=0, time 00:00.00 after release.
- Start press: hold key_start low for 3 clk_100hz periods -> running=1 exactly one cycle after the 3rd sample; 150 further ticks -> time 00:01.50.
- Bounce: key_start low for 2 samples, high 1, low 2 -> no event, state stays IDLE.
- Rollover: preload via 359999 ticks to 59:59.99, one more tick_100 -> 00:00.00, running stays 1.
- Clear priority: in PAUSE at 00:12.34, start and clear accepted on the same tick_100 -> IDLE, time 00:00.00; the same pair in RUN -> PAUSE, time retained.
- Scan/LAP: 6 tick_1k -> an sequence 3E,3D,3B,37,2F,1F with dp low only at 3B and 2F. With STOPWATCH_LAP_EN, lap at 00:02.00 then 100 ticks -> display shows 00:02.00, internal time 00:03.00; second lap -> display 00:03.00.
